// File: rtl/gtfmac_vnc_lat_pkg.sv
// Shared defaults and helpers for the multi-channel latency monitor.
// Holds the default widths/depths, the per-channel statistics record,
// and the saturating arithmetic used by the statistics pipeline.
package gtfmac_vnc_lat_pkg;

    localparam int LAT_TIMER_W = 16;
    localparam int LAT_NUM_CH  = 4;
    localparam int LAT_CH_W    = 2;
    localparam int LAT_PEND_D  = 16;
    localparam int LAT_PEND_AW = 4;
    localparam int LAT_ACCU_W  = 32;
    localparam int LAT_CNT_W   = 32;
    localparam int LAT_EVT_W   = 16;

    // Per-channel statistics record at the default widths.
    typedef struct packed {
        logic [LAT_CNT_W-1:0]   idx;
        logic [LAT_ACCU_W-1:0]  accu;
        logic [LAT_TIMER_W-1:0] max;
        logic [LAT_TIMER_W-1:0] min;
        logic [LAT_EVT_W-1:0]   ovf;
        logic [LAT_EVT_W-1:0]   orphan;
    } lat_stats_t;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [LAT_EVT_W-1:0] sat_inc16(input logic [LAT_EVT_W-1:0] v);
        return (v == '1) ? v : v + LAT_EVT_W'(1);
    endfunction

    // Saturating accumulate of a delta into a default-width accumulator.
    function automatic logic [LAT_ACCU_W-1:0] sat_add_accu(input logic [LAT_ACCU_W-1:0] a,
                                                           input logic [LAT_TIMER_W-1:0] d);
        logic [LAT_ACCU_W:0] s;
        s = {1'b0, a} + {{(LAT_ACCU_W - LAT_TIMER_W + 1){1'b0}}, d};
        return s[LAT_ACCU_W] ? '1 : s[LAT_ACCU_W-1:0];
    endfunction

endpackage

// File: rtl/gtfmac_vnc_lat_pend_fifo.sv
// Pending-timestamp FIFO, one per monitored channel.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush        synchronous empty (pointers and level to zero)
//   push, din    write request and timestamp
//   pop          read request; ignored when empty
//   head         oldest stored timestamp
//   level        occupancy 0..DEPTH
//   full, empty  occupancy flags
// A push while full is accepted only when a pop retires the head in the
// same cycle, so a saturated queue keeps streaming without losing stamps.
module gtfmac_vnc_lat_pend_fifo
    import gtfmac_vnc_lat_pkg::*;
#(
    parameter int WIDTH = LAT_TIMER_W,
    parameter int DEPTH = LAT_PEND_D,
    parameter int AW    = LAT_PEND_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 level_q, level_d;
    logic                        do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/gtfmac_vnc_lat_mon_mc.sv
// Multi-channel latency monitor.
// Pairs per-channel send/receive pulses against a free-running timer,
// queueing outstanding send stamps per channel so pipelined traffic is
// matched in order, and keeps per-channel delta statistics.
// Ports:
//   lat_clk, lat_rstn    clock, asynchronous active-low reset
//   go, clear            capture enable level, single-cycle clear
//   lat_pkt_cnt          samples per channel before done (0 = never)
//   adj_factor           constant subtracted from every delta
//   sent_evt, rcvd_evt   per-channel event pulses
//   rd_ch                channel select for stat_* (registered)
//   delta_valid/time     per-channel delta strobe and latest delta
//   stat_*               selected channel statistics and queue level
//   done, all_done       per-channel sample target reached, AND of done
// Pipeline: event at edge N -> delta_valid/delta_time after N,
// statistics and done after N+1, stat_* mux after N+2.
module gtfmac_vnc_lat_mon_mc
    import gtfmac_vnc_lat_pkg::*;
#(
    parameter int TIMER_WIDTH = LAT_TIMER_W,
    parameter int NUM_CH      = LAT_NUM_CH,
    parameter int CH_W        = LAT_CH_W,
    parameter int PEND_DEPTH  = LAT_PEND_D,
    parameter int PEND_AW     = LAT_PEND_AW,
    parameter int ACCU_WIDTH  = LAT_ACCU_W,
    parameter int CNT_WIDTH   = LAT_CNT_W
) (
    input  logic                          lat_clk,
    input  logic                          lat_rstn,
    input  logic                          go,
    input  logic                          clear,
    input  logic [CNT_WIDTH-1:0]          lat_pkt_cnt,
    input  logic [TIMER_WIDTH-1:0]        adj_factor,
    input  logic [NUM_CH-1:0]             sent_evt,
    input  logic [NUM_CH-1:0]             rcvd_evt,
    input  logic [CH_W-1:0]               rd_ch,
    output logic [NUM_CH-1:0]             delta_valid,
    output logic [NUM_CH*TIMER_WIDTH-1:0] delta_time,
    output logic [CNT_WIDTH-1:0]          stat_idx,
    output logic [ACCU_WIDTH-1:0]         stat_accu,
    output logic [TIMER_WIDTH-1:0]        stat_max,
    output logic [TIMER_WIDTH-1:0]        stat_min,
    output logic [15:0]                   stat_ovf,
    output logic [15:0]                   stat_orphan,
    output logic [PEND_AW:0]              stat_level,
    output logic [NUM_CH-1:0]             done,
    output logic                          all_done
);

    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    // Holds off capture for one edge after reset release.
    logic                   arm_q, arm_d;

    logic [NUM_CH-1:0]                  en, push, pop, ovf_inc, orph_inc;
    logic [NUM_CH-1:0][TIMER_WIDTH-1:0] fifo_head;
    logic [NUM_CH-1:0][PEND_AW:0]       fifo_level;
    logic [NUM_CH-1:0]                  fifo_full, fifo_empty;

    logic [NUM_CH-1:0]                  delta_valid_q, delta_valid_d;
    logic [NUM_CH-1:0][TIMER_WIDTH-1:0] delta_time_q, delta_time_d;

    logic [NUM_CH-1:0][CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0][ACCU_WIDTH-1:0]  accu_q, accu_d;
    logic [NUM_CH-1:0][ACCU_WIDTH:0]    accu_sum;
    logic [NUM_CH-1:0][TIMER_WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic [NUM_CH-1:0][15:0]            ovf_q, ovf_d, orphan_q, orphan_d;
    logic [NUM_CH-1:0]                  done_q, done_d;

    logic [CNT_WIDTH-1:0]   stat_idx_q, stat_idx_d;
    logic [ACCU_WIDTH-1:0]  stat_accu_q, stat_accu_d;
    logic [TIMER_WIDTH-1:0] stat_max_q, stat_max_d, stat_min_q, stat_min_d;
    logic [15:0]            stat_ovf_q, stat_ovf_d, stat_orphan_q, stat_orphan_d;
    logic [PEND_AW:0]       stat_level_q, stat_level_d;

    always_comb begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        arm_d   = 1'b1;
    end

    // Capture gating; clear suppresses every same-cycle event.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            en[c]   = go & ~done_q[c] & ~clear & arm_q;
            push[c] = en[c] & sent_evt[c];
            pop[c]  = en[c] & rcvd_evt[c];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gtfmac_vnc_lat_pend_fifo #(
            .WIDTH (TIMER_WIDTH),
            .DEPTH (PEND_DEPTH),
            .AW    (PEND_AW)
        ) u_fifo (
            .clk   (lat_clk),
            .rst_n (lat_rstn),
            .flush (clear),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (timer_q),
            .head  (fifo_head[g]),
            .level (fifo_level[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // A receive only matches a stamp already queued, so an empty queue makes
    // it an orphan even if a send lands in the same cycle. Modular
    // subtraction absorbs timer wrap.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ovf_inc[c]       = push[c] & fifo_full[c] & ~pop[c];
            orph_inc[c]      = pop[c] & fifo_empty[c];
            delta_valid_d[c] = pop[c] & ~fifo_empty[c];
            delta_time_d[c]  = delta_valid_d[c] ? (timer_q - fifo_head[c] - adj_factor)
                                                : delta_time_q[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            accu_sum[c] = {1'b0, accu_q[c]}
                        + {{(ACCU_WIDTH - TIMER_WIDTH + 1){1'b0}}, delta_time_q[c]};
            idx_d[c]    = idx_q[c];
            accu_d[c]   = accu_q[c];
            max_d[c]    = max_q[c];
            min_d[c]    = min_q[c];
            ovf_d[c]    = ovf_q[c];
            orphan_d[c] = orphan_q[c];
            done_d[c]   = done_q[c];
            if (clear) begin
                idx_d[c]    = '0;
                accu_d[c]   = '0;
                max_d[c]    = '0;
                min_d[c]    = '1;
                ovf_d[c]    = '0;
                orphan_d[c] = '0;
                done_d[c]   = 1'b0;
            end else begin
                if (ovf_inc[c])  ovf_d[c]    = sat_inc16(ovf_q[c]);
                if (orph_inc[c]) orphan_d[c] = sat_inc16(orphan_q[c]);
                if (delta_valid_q[c] && !done_q[c]) begin
                    idx_d[c]  = (idx_q[c] == '1) ? idx_q[c] : idx_q[c] + CNT_WIDTH'(1);
                    accu_d[c] = accu_sum[c][ACCU_WIDTH] ? '1 : accu_sum[c][ACCU_WIDTH-1:0];
                    if (delta_time_q[c] > max_q[c]) max_d[c] = delta_time_q[c];
                    if (delta_time_q[c] < min_q[c]) min_d[c] = delta_time_q[c];
                end
                if ((lat_pkt_cnt != '0) && (idx_d[c] == lat_pkt_cnt)) done_d[c] = 1'b1;
            end
        end
    end

    // Unselected encodings (rd_ch >= NUM_CH) read back as zeros.
    always_comb begin
        stat_idx_d    = '0;
        stat_accu_d   = '0;
        stat_max_d    = '0;
        stat_min_d    = '0;
        stat_ovf_d    = '0;
        stat_orphan_d = '0;
        stat_level_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                stat_idx_d    = idx_q[c];
                stat_accu_d   = accu_q[c];
                stat_max_d    = max_q[c];
                stat_min_d    = min_q[c];
                stat_ovf_d    = ovf_q[c];
                stat_orphan_d = orphan_q[c];
                stat_level_d  = fifo_level[c];
            end
        end
    end

    always_ff @(posedge lat_clk or negedge lat_rstn) begin
        if (!lat_rstn) begin
            timer_q       <= '0;
            arm_q         <= 1'b0;
            delta_valid_q <= '0;
            delta_time_q  <= '0;
            idx_q         <= '0;
            accu_q        <= '0;
            max_q         <= '0;
            min_q         <= '1;
            ovf_q         <= '0;
            orphan_q      <= '0;
            done_q        <= '0;
            stat_idx_q    <= '0;
            stat_accu_q   <= '0;
            stat_max_q    <= '0;
            stat_min_q    <= '1;
            stat_ovf_q    <= '0;
            stat_orphan_q <= '0;
            stat_level_q  <= '0;
        end else begin
            timer_q       <= timer_d;
            arm_q         <= arm_d;
            delta_valid_q <= delta_valid_d;
            delta_time_q  <= delta_time_d;
            idx_q         <= idx_d;
            accu_q        <= accu_d;
            max_q         <= max_d;
            min_q         <= min_d;
            ovf_q         <= ovf_d;
            orphan_q      <= orphan_d;
            done_q        <= done_d;
            stat_idx_q    <= stat_idx_d;
            stat_accu_q   <= stat_accu_d;
            stat_max_q    <= stat_max_d;
            stat_min_q    <= stat_min_d;
            stat_ovf_q    <= stat_ovf_d;
            stat_orphan_q <= stat_orphan_d;
            stat_level_q  <= stat_level_d;
        end
    end

    assign delta_valid = delta_valid_q;
    assign delta_time  = delta_time_q;
    assign stat_idx    = stat_idx_q;
    assign stat_accu   = stat_accu_q;
    assign stat_max    = stat_max_q;
    assign stat_min    = stat_min_q;
    assign stat_ovf    = stat_ovf_q;
    assign stat_orphan = stat_orphan_q;
    assign stat_level  = stat_level_q;
    assign done        = done_q;
    assign all_done    = &done_q;

endmodule

// File: tb/tb_gtfmac_vnc_lat_mon_mc.sv
// Bench for gtfmac_vnc_lat_mon_mc: directed steps plus a randomized phase,
// checked against a queue-based reference of the latency rules.
module tb_gtfmac_vnc_lat_mon_mc;

    localparam int NCH = 4;
    localparam int PD  = 16;

    logic        lat_clk = 1'b0;
    logic        lat_rstn = 1'b0;
    logic        go = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] lat_pkt_cnt = '0;
    logic [15:0] adj_factor = '0;
    logic [3:0]  sent_evt = '0;
    logic [3:0]  rcvd_evt = '0;
    logic [1:0]  rd_ch = '0;
    logic [3:0]  delta_valid;
    logic [63:0] delta_time;
    logic [31:0] stat_idx;
    logic [31:0] stat_accu;
    logic [15:0] stat_max, stat_min, stat_ovf, stat_orphan;
    logic [4:0]  stat_level;
    logic [3:0]  done;
    logic        all_done;

    gtfmac_vnc_lat_mon_mc dut (
        .lat_clk     (lat_clk),
        .lat_rstn    (lat_rstn),
        .go          (go),
        .clear       (clear),
        .lat_pkt_cnt (lat_pkt_cnt),
        .adj_factor  (adj_factor),
        .sent_evt    (sent_evt),
        .rcvd_evt    (rcvd_evt),
        .rd_ch       (rd_ch),
        .delta_valid (delta_valid),
        .delta_time  (delta_time),
        .stat_idx    (stat_idx),
        .stat_accu   (stat_accu),
        .stat_max    (stat_max),
        .stat_min    (stat_min),
        .stat_ovf    (stat_ovf),
        .stat_orphan (stat_orphan),
        .stat_level  (stat_level),
        .done        (done),
        .all_done    (all_done)
    );

    always #5 lat_clk = ~lat_clk;

    // Edges since reset release: equals the timer value the next edge samples.
    int unsigned cyc;
    always @(posedge lat_clk or negedge lat_rstn)
        if (!lat_rstn) cyc <= 0;
        else           cyc <= cyc + 1;

    // Reference state per channel.
    int unsigned     q[NCH][$];
    int unsigned     m_idx[NCH], m_max[NCH], m_min[NCH], m_ovf[NCH], m_orph[NCH];
    longint unsigned m_accu[NCH];
    bit              m_done[NCH];

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) begin
            q[c].delete();
            m_idx[c] = 0; m_accu[c] = 0; m_max[c] = 0; m_min[c] = 32'hFFFF;
            m_ovf[c] = 0; m_orph[c] = 0; m_done[c] = 0;
        end
    endtask

    // One cycle of events; starts and ends at a falling edge.
    task automatic step(input logic [3:0] s, input logic [3:0] r);
        logic [3:0]           edv;
        logic [NCH-1:0][15:0] edt;
        int unsigned          t, st, d;
        t = cyc & 32'hFFFF;
        edv = '0;
        edt = '0;
        sent_evt = s;
        rcvd_evt = r;
        for (int c = 0; c < NCH; c++) begin
            if (go && !m_done[c]) begin
                if (r[c]) begin
                    if (q[c].size() != 0) begin
                        st = q[c].pop_front();
                        d = (t - st - adj_factor) & 32'hFFFF;
                        edv[c] = 1'b1;
                        edt[c] = d[15:0];
                        m_idx[c]++;
                        m_accu[c] += d;
                        if (m_accu[c] > 64'hFFFF_FFFF) m_accu[c] = 64'hFFFF_FFFF;
                        if (d > m_max[c]) m_max[c] = d;
                        if (d < m_min[c]) m_min[c] = d;
                        if (lat_pkt_cnt != 0 && m_idx[c] == lat_pkt_cnt) m_done[c] = 1'b1;
                    end else if (m_orph[c] < 65535) m_orph[c]++;
                end
                if (s[c]) begin
                    if (q[c].size() < PD) q[c].push_back(t);
                    else if (m_ovf[c] < 65535) m_ovf[c]++;
                end
            end
        end
        @(posedge lat_clk);
        @(negedge lat_clk);
        sent_evt = '0;
        rcvd_evt = '0;
        chk("delta_valid", delta_valid, edv);
        for (int c = 0; c < NCH; c++)
            if (edv[c]) chk($sformatf("delta_time%0d", c), delta_time[c*16 +: 16], edt[c]);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'h0, 4'h0);
    endtask

    task automatic idle_to(input int unsigned target);
        while (cyc < target) @(negedge lat_clk);
    endtask

    task automatic check_stats(input int c);
        logic [1:0] sel;
        sel = c[1:0];
        rd_ch = sel;
        idle(3);
        chk($sformatf("idx%0d", c),    stat_idx,    m_idx[c]);
        chk($sformatf("accu%0d", c),   stat_accu,   m_accu[c]);
        chk($sformatf("max%0d", c),    stat_max,    m_max[c]);
        chk($sformatf("min%0d", c),    stat_min,    m_min[c]);
        chk($sformatf("ovf%0d", c),    stat_ovf,    m_ovf[c]);
        chk($sformatf("orphan%0d", c), stat_orphan, m_orph[c]);
        chk($sformatf("level%0d", c),  stat_level,  q[c].size());
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge lat_clk);
        @(negedge lat_clk);
        clear = 1'b0;
        m_reset();
        chk("clear_dv", delta_valid, 4'h0);
    endtask

    initial begin
        int unsigned t0;
        logic [3:0]  rs, rr;
        m_reset();

        // Reset state
        repeat (3) @(negedge lat_clk);
        chk("rst_dv", delta_valid, 4'h0);
        chk("rst_dt", delta_time, 64'h0);
        chk("rst_done", done, 4'h0);
        chk("rst_all_done", all_done, 1'b0);
        chk("rst_idx", stat_idx, 32'h0);
        chk("rst_accu", stat_accu, 32'h0);
        chk("rst_max", stat_max, 16'h0);
        chk("rst_min", stat_min, 16'hFFFF);
        chk("rst_ovf", stat_ovf, 16'h0);
        chk("rst_orphan", stat_orphan, 16'h0);
        chk("rst_level", stat_level, 5'h0);
        lat_rstn = 1'b1;
        idle(3);

        // Ch0: send at 100, receive at 140, adj 4
        go = 1'b1;
        adj_factor = 16'd4;
        idle_to(100);
        step(4'b0001, 4'b0000);
        idle_to(140);
        step(4'b0000, 4'b0001);
        chk("ch0_delta36", delta_time[15:0], 16'd36);
        check_stats(0);
        chk("ch0_max36", stat_max, 16'd36);
        chk("ch0_min36", stat_min, 16'd36);

        // Ch1: five pipelined sends, five in-order receives 40 cycles later
        adj_factor = 16'd0;
        t0 = cyc;
        repeat (5) step(4'b0010, 4'b0000);
        rd_ch = 2'd1;
        idle(3);
        chk("ch1_level5", stat_level, 5'd5);
        idle_to(t0 + 40);
        repeat (5) begin
            step(4'b0000, 4'b0010);
            chk("ch1_delta40", delta_time[31:16], 16'd40);
        end
        check_stats(1);
        chk("ch1_level0", stat_level, 5'd0);

        // Ch2: overflow, then send+receive on a full queue
        repeat (PD + 2) step(4'b0100, 4'b0000);
        check_stats(2);
        chk("ch2_ovf2", stat_ovf, 16'd2);
        chk("ch2_full", stat_level, 5'd16);
        step(4'b0100, 4'b0100);
        check_stats(2);
        chk("ch2_ovf_hold", stat_ovf, 16'd2);
        chk("ch2_level_hold", stat_level, 5'd16);

        // Ch3: orphan receives
        step(4'b0000, 4'b1000);
        check_stats(3);
        chk("ch3_orphan1", stat_orphan, 16'd1);
        step(4'b1000, 4'b1000);
        check_stats(3);
        chk("ch3_orphan2", stat_orphan, 16'd2);
        chk("ch3_level1", stat_level, 5'd1);

        // Sample target on all channels, then clear
        do_clear();
        lat_pkt_cnt = 32'd3;
        repeat (4) begin
            step(4'hF, 4'h0);
            idle(2);
            step(4'h0, 4'hF);
            idle(4);
        end
        for (int c = 0; c < NCH; c++) check_stats(c);
        chk("idx_at_target", stat_idx, 32'd3);
        chk("done_all", done, 4'hF);
        chk("all_done", all_done, 1'b1);
        do_clear();
        lat_pkt_cnt = 32'd0;
        check_stats(0);
        chk("clr_idx", stat_idx, 32'd0);
        chk("clr_min", stat_min, 16'hFFFF);
        chk("clr_done", done, 4'h0);
        chk("clr_all_done", all_done, 1'b0);

        // Randomized traffic with go toggling
        adj_factor = 16'($urandom_range(0, 7));
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) go = ~go;
            rs = '0;
            rr = '0;
            for (int c = 0; c < NCH; c++) begin
                rs[c] = ($urandom_range(0, 2) == 0);
                rr[c] = ($urandom_range(0, 2) == 0);
            end
            step(rs, rr);
        end
        go = 1'b1;
        for (int c = 0; c < NCH; c++) check_stats(c);

        // Timer wrap: send at 0xFFF0, receive at 0x0010
        do_clear();
        adj_factor = 16'd0;
        idle_to(32'hFFF0);
        step(4'b0001, 4'b0000);
        idle_to(32'h1_0010);
        step(4'b0000, 4'b0001);
        chk("wrap_delta", delta_time[15:0], 16'h0020);

        // Asynchronous reset mid-operation
        step(4'b0001, 4'b0000);
        check_stats(0);
        lat_rstn = 1'b0;
        #1;
        chk("arst_level", stat_level, 5'd0);
        chk("arst_min", stat_min, 16'hFFFF);
        chk("arst_idx", stat_idx, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
